// File: rtl/branch_resolve_if.sv
// branch_resolve_if: IF prediction lookup, EX branch operands and registered resolution.
// master drives the pipeline side, slave is the branch resolve unit.
interface branch_resolve_if #(parameter int XLEN = 32);
    logic [XLEN-1:0] if_pc_i;
    logic            pred_taken_o;
    logic            br_valid_i;
    logic            kill_i;
    logic [2:0]      func3_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic [XLEN-1:0] pc_i;
    logic [XLEN-1:0] imm_i;
    logic            pred_taken_i;
    logic            res_valid_o;
    logic            taken_o;
    logic            mispredict_o;
    logic [XLEN-1:0] redirect_pc_o;
    logic            illegal_o;
    modport master (
        output if_pc_i, br_valid_i, kill_i, func3_i, rs1_i, rs2_i, pc_i, imm_i, pred_taken_i,
        input  pred_taken_o, res_valid_o, taken_o, mispredict_o, redirect_pc_o, illegal_o
    );
    modport slave (
        input  if_pc_i, br_valid_i, kill_i, func3_i, rs1_i, rs2_i, pc_i, imm_i, pred_taken_i,
        output pred_taken_o, res_valid_o, taken_o, mispredict_o, redirect_pc_o, illegal_o
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: RV32 branch condition evaluation, bimodal 2-bit BHT and registered redirect.
// Optional BRU_PERF_CNT_EN adds branch and mispredict counters.
module branch_resolve_unit #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    branch_resolve_if.slave   bus
`ifdef BRU_PERF_CNT_EN
    ,
    output logic [31:0]       br_count_o,
    output logic [31:0]       mispred_count_o
`endif
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]      bht_q [BHT_ENTRIES];
    logic            res_valid_q, taken_q, mispredict_q, illegal_q;
    logic [XLEN-1:0] redirect_q, redirect_d;
    logic [XLEN:0]   diff;
    logic            acc, z, c, n, v, illegal, taken, mispredict_d;
    logic [IDX_W-1:0] wr_idx;
    logic [1:0]      ctr, ctr_d;
    logic            unused_pc_bits;

    always_comb begin
        acc          = bus.br_valid_i & ~bus.kill_i;
        diff         = {1'b0, bus.rs1_i} + {1'b0, ~bus.rs2_i} + (XLEN+1)'(1);
        z            = diff[XLEN-1:0] == '0;
        c            = diff[XLEN];
        n            = diff[XLEN-1];
        v            = (bus.rs1_i[XLEN-1] != bus.rs2_i[XLEN-1]) & (n != bus.rs1_i[XLEN-1]);
        illegal      = bus.func3_i[2:1] == 2'b01;
        taken        = bus.func3_i == 3'd0 ? z :
                       bus.func3_i == 3'd1 ? ~z :
                       bus.func3_i == 3'd4 ? n != v :
                       bus.func3_i == 3'd5 ? n == v :
                       bus.func3_i == 3'd6 ? ~c :
                       bus.func3_i == 3'd7 ? c : 1'b0;
        mispredict_d = taken != bus.pred_taken_i;
        redirect_d   = taken ? bus.pc_i + bus.imm_i : bus.pc_i + XLEN'(4);
        wr_idx       = bus.pc_i[IDX_W+1:2];
        ctr          = bht_q[wr_idx];
        ctr_d        = taken ? ctr + {1'b0, ctr != 2'd3} : ctr - {1'b0, ctr != 2'd0};
    end

    // Reads the registered table, so a same-cycle update is not yet visible (read-before-write)
    assign bus.pred_taken_o  = bht_q[bus.if_pc_i[IDX_W+1:2]][1];
    assign bus.res_valid_o   = res_valid_q;
    assign bus.taken_o       = taken_q;
    assign bus.mispredict_o  = mispredict_q;
    assign bus.redirect_pc_o = redirect_q;
    assign bus.illegal_o     = illegal_q;
    assign unused_pc_bits    = &{1'b0, bus.if_pc_i, bus.pc_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q  <= 1'b0;
            taken_q      <= 1'b0;
            mispredict_q <= 1'b0;
            illegal_q    <= 1'b0;
            redirect_q   <= '0;
            for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'd1;
        end else begin
            res_valid_q  <= acc;
            taken_q      <= acc & taken;
            mispredict_q <= acc & mispredict_d;
            illegal_q    <= acc & illegal;
            if (acc) redirect_q <= redirect_d;
            if (acc && !illegal) bht_q[wr_idx] <= ctr_d;
        end
    end

`ifdef BRU_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count_o      <= '0;
            mispred_count_o <= '0;
        end else begin
            if (acc && !illegal) br_count_o <= br_count_o + 32'd1;
            if (acc && mispredict_d) mispred_count_o <= mispred_count_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed and randomized checks against a behavioural branch/BHT model.
module tb_branch_resolve_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   passed = 0;
    int   ctr [16];
    logic [31:0] last_redirect = '0;
    int   m_br = 0;
    int   m_mis = 0;

    branch_resolve_if #(.XLEN(32)) bru_if ();
`ifdef BRU_PERF_CNT_EN
    logic [31:0] br_count, mispred_count;
`endif

    branch_resolve_unit #(.XLEN(32), .BHT_ENTRIES(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bru_if)
`ifdef BRU_PERF_CNT_EN
        , .br_count_o (br_count), .mispred_count_o (mispred_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic int idx(input logic [31:0] pc);
        return int'((pc >> 2) & 32'hF);
    endfunction

    function automatic logic outcome(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) < $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) ctr[i] = 1;
        last_redirect = '0;
        m_br = 0;
        m_mis = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(bru_if.res_valid_o), 0);
        chk({tag, "_taken"}, 32'(bru_if.taken_o), 0);
        chk({tag, "_misp"}, 32'(bru_if.mispredict_o), 0);
        chk({tag, "_redir"}, bru_if.redirect_pc_o, 0);
        chk({tag, "_illegal"}, 32'(bru_if.illegal_o), 0);
        chk({tag, "_pred"}, 32'(bru_if.pred_taken_o), 0);
    endtask

    // One cycle: drive at negedge, check prediction before and after the edge, check results after it
    task automatic step(input logic v, input logic k, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] pc, input logic [31:0] imm,
                        input logic p, input logic [31:0] ipc);
        logic acc, t, ill;
        @(negedge clk);
        bru_if.br_valid_i = v;  bru_if.kill_i = k;  bru_if.func3_i = f;
        bru_if.rs1_i = a;  bru_if.rs2_i = b;  bru_if.pc_i = pc;  bru_if.imm_i = imm;
        bru_if.pred_taken_i = p;  bru_if.if_pc_i = ipc;
        #1 chk("pred_pre", 32'(bru_if.pred_taken_o), 32'(ctr[idx(ipc)] >= 2));
        acc = v && !k;
        ill = (f == 3'd2) || (f == 3'd3);
        t = outcome(f, a, b);
        if (acc) begin
            last_redirect = t ? pc + imm : pc + 32'd4;
            if (!ill) begin
                ctr[idx(pc)] = t ? (ctr[idx(pc)] < 3 ? ctr[idx(pc)] + 1 : 3)
                                 : (ctr[idx(pc)] > 0 ? ctr[idx(pc)] - 1 : 0);
                m_br++;
            end
            if (t != p) m_mis++;
        end
        @(posedge clk);
        #1;
        chk("res_valid", 32'(bru_if.res_valid_o), 32'(acc));
        chk("taken", 32'(bru_if.taken_o), 32'(acc && t));
        chk("mispredict", 32'(bru_if.mispredict_o), 32'(acc && (t != p)));
        chk("illegal", 32'(bru_if.illegal_o), 32'(acc && ill));
        chk("redirect", bru_if.redirect_pc_o, last_redirect);
        chk("pred_post", 32'(bru_if.pred_taken_o), 32'(ctr[idx(ipc)] >= 2));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 3'd0, 0, 0, 0, 0, 1'b0, 32'h40);
    endtask

    initial begin
        logic [31:0] a, b;
        logic [2:0]  f;
        bru_if.br_valid_i = 0;  bru_if.kill_i = 0;  bru_if.func3_i = 0;
        bru_if.rs1_i = 0;  bru_if.rs2_i = 0;  bru_if.pc_i = 0;  bru_if.imm_i = 0;
        bru_if.pred_taken_i = 0;  bru_if.if_pc_i = 32'h100;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        step(1, 0, 3'd0, 32'h5, 32'h5, 32'h100, 32'h20, 0, 32'h100);
        chk("beq_redirect_0x120", bru_if.redirect_pc_o, 32'h120);
        chk("beq_pred_now_1", 32'(bru_if.pred_taken_o), 1);
        step(1, 0, 3'd4, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h40, 0, 32'h200);
        step(1, 0, 3'd6, 32'hFFFF_FFFF, 32'h1, 32'h204, 32'h40, 1, 32'h204);
        chk("bltu_redirect_pc4", bru_if.redirect_pc_o, 32'h208);
        step(1, 0, 3'd5, 32'hFFFF_FFFF, 32'h1, 32'h208, 32'h40, 0, 32'h208);
        step(1, 0, 3'd7, 32'hFFFF_FFFF, 32'h1, 32'h20C, 32'h40, 0, 32'h20C);
        step(1, 0, 3'd4, 32'h8000_0000, 32'h1, 32'h210, 32'h10, 0, 32'h210);
        step(1, 0, 3'd1, 32'h1, 32'h2, 32'hFFFF_FFF0, 32'h20, 1, 32'h0);
        chk("wrap_target", bru_if.redirect_pc_o, 32'h10);
        for (int i = 0; i < 5; i++) step(1, 0, 3'd0, 7, 7, 32'h40, 32'h8, 1, 32'h40);
        chk("sat_at_3", 32'(ctr[0]), 3);
        step(1, 0, 3'd1, 7, 7, 32'h40, 32'h8, 1, 32'h40);
        chk("after_nt_pred", 32'(bru_if.pred_taken_o), 1);
        step(1, 1, 3'd0, 7, 7, 32'h44, 32'h8, 0, 32'h44);
        step(1, 0, 3'd2, 7, 7, 32'h44, 32'h8, 1, 32'h44);
        step(1, 0, 3'd3, 7, 8, 32'h48, 32'h8, 0, 32'h48);
        idle();

        // asynchronous reset between accept and the result edge
        @(negedge clk);
        bru_if.br_valid_i = 1;  bru_if.func3_i = 3'd0;  bru_if.rs1_i = 1;  bru_if.rs2_i = 1;
        bru_if.pc_i = 32'h40;  bru_if.pred_taken_i = 0;  bru_if.if_pc_i = 32'h40;
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_reset_outputs("midrst");
        @(posedge clk);
        #1 check_reset_outputs("midrst_hold");
        bru_if.br_valid_i = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // collision: counter 1 taken at 0x40 while IF reads 0x40
        step(1, 0, 3'd0, 3, 3, 32'h40, 32'h4, 0, 32'h40);
        chk("collision_post", 32'(bru_if.pred_taken_o), 1);

        for (int i = 0; i < 300; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : ($urandom_range(0, 3) == 0 ? {a[31], b[30:0]} ^ 32'h1 : $urandom);
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            if ($urandom_range(0, 7) == 0) b = 32'h7FFF_FFFF;
            step(1'($urandom_range(0, 5) != 0), 1'($urandom_range(0, 7) == 0), f, a, b,
                 {$urandom_range(0, 3) == 0 ? 28'hFFF_FFFF : 28'($urandom_range(0, 3)), 2'($urandom), 2'b00},
                 $urandom & 32'hFFFF_FFFE, 1'($urandom), {26'($urandom_range(0, 2)), 4'($urandom), 2'b00});
        end
`ifdef BRU_PERF_CNT_EN
        chk("br_count", br_count, 32'(m_br));
        chk("mispred_count", mispred_count, 32'(m_mis));
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
